// File: rtl/matrix_eth_tx.sv
// RMII transmit framer: preamble/SFD, Ethernet II header, streamed payload,
// CRC-32 FCS and inter-frame gap, emitted as dibits on eth_refclk.
module matrix_eth_tx #(
  parameter int unsigned PAYLOAD_BYTES = 1024,
  parameter logic [47:0] DST_MAC       = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC       = 48'h0000_0000_0001,
  parameter logic [15:0] ETHERTYPE     = 16'h88B5,
  parameter int unsigned IFG_CYCLES    = 48
) (
  input  logic       eth_refclk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       data_request,
  output logic       eth_txen,
  output logic [1:0] eth_txd,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int unsigned MAXB = (PAYLOAD_BYTES > 14) ? PAYLOAD_BYTES : 14;
  localparam int unsigned CW   = $clog2(MAXB);
  localparam int unsigned IW   = $clog2(IFG_CYCLES + 1);
  localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_PAY,
    S_FCS,
    S_IFG
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ifg_q, ifg_d;
  logic [7:0]    shift_q, shift_d;
  logic [31:0]   crc_q, crc_d;
  logic          txen_q, txen_d;
  logic [1:0]    txd_q, txd_d;
  logic          dreq_q, dreq_d;
  logic          done_q, done_d;
  logic          und_q, und_d;

  logic [7:0]    hdr_byte;
  logic [7:0]    pay_byte;
  logic [1:0]    hdr_dibit;
  logic [1:0]    pay_dibit;
  logic [1:0]    fcs_dibit;
  logic          byte_end;

  // Reflected CRC-32 advanced by one dibit, bit 0 first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // Dibit selection for header, payload and FCS from the current counters.
  always_comb begin
    hdr_byte  = 8'(HDR >> {4'd13 - cnt_q[3:0], 3'b000});
    pay_byte  = (phase_q == 2'd0) ? byte_in : shift_q;
    hdr_dibit = 2'(hdr_byte >> {phase_q, 1'b0});
    pay_dibit = 2'(pay_byte >> {phase_q, 1'b0});
    fcs_dibit = 2'(~crc_q >> {cnt_q[1:0], phase_q, 1'b0});
    byte_end  = (phase_q == 2'd3);
  end

  // Next-state, counter sequencing and registered-output values.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 2'd1;
    cnt_d   = byte_end ? cnt_q + CW'(1) : cnt_q;
    ifg_d   = ifg_q;
    shift_d = shift_q;
    crc_d   = crc_q;
    txen_d  = 1'b0;
    txd_d   = 2'b00;
    dreq_d  = 1'b0;
    done_d  = 1'b0;
    und_d   = und_q;
    unique case (state_q)
      S_IDLE: begin
        phase_d = 2'd0;
        cnt_d   = '0;
        if (start) begin
          state_d = S_PRE;
          dreq_d  = 1'b1;
          und_d   = 1'b0;
          crc_d   = '1;
        end
      end
      S_PRE: begin
        txen_d = 1'b1;
        txd_d  = (cnt_q == CW'(7) && byte_end) ? 2'b11 : 2'b01;
        if (cnt_q == CW'(7) && byte_end) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end
      S_HDR: begin
        txen_d = 1'b1;
        txd_d  = hdr_dibit;
        crc_d  = crc_dibit(crc_q, hdr_dibit);
        if (cnt_q == CW'(13) && byte_end) begin
          state_d = S_PAY;
          cnt_d   = '0;
        end
      end
      S_PAY: begin
        if (phase_q == 2'd0 && !byte_valid) begin
          und_d   = 1'b1;
          state_d = S_IFG;
          ifg_d   = '0;
        end else begin
          txen_d = 1'b1;
          txd_d  = pay_dibit;
          crc_d  = crc_dibit(crc_q, pay_dibit);
          if (phase_q == 2'd0) shift_d = byte_in;
          if (cnt_q == CW'(PAYLOAD_BYTES - 1) && byte_end) begin
            state_d = S_FCS;
            cnt_d   = '0;
          end
        end
      end
      S_FCS: begin
        txen_d = 1'b1;
        txd_d  = fcs_dibit;
        if (cnt_q == CW'(3) && byte_end) begin
          done_d  = 1'b1;
          state_d = S_IFG;
          ifg_d   = '0;
        end
      end
      S_IFG: begin
        ifg_d = ifg_q + IW'(1);
        if (ifg_q == IW'(IFG_CYCLES - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      ifg_q   <= '0;
      shift_q <= '0;
      crc_q   <= '1;
      txen_q  <= 1'b0;
      txd_q   <= '0;
      dreq_q  <= 1'b0;
      done_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      ifg_q   <= ifg_d;
      shift_q <= shift_d;
      crc_q   <= crc_d;
      txen_q  <= txen_d;
      txd_q   <= txd_d;
      dreq_q  <= dreq_d;
      done_q  <= done_d;
      und_q   <= und_d;
    end
  end

  assign data_request = dreq_q;
  assign eth_txen     = txen_q;
  assign eth_txd      = txd_q;
  assign done         = done_q;
  assign underrun     = und_q;
  assign busy         = (state_q != S_IDLE);

endmodule
